// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads instruction memory and buffers
// {pc, instr} pairs in a small FIFO for decode. Handles redirect flush and halt.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [31:0]                   imem_addr,
  input  logic [31:0]                   imem_instr,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  input  logic                          halt_req,
  output logic                          if_valid,
  input  logic                          if_ready,
  output logic [31:0]                   if_instr,
  output logic [31:0]                   if_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          misalign_pulse
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } state_t;

  state_t         state;
  logic [31:0]    fetch_pc;
  logic [31:0]    pc_mem    [FIFO_DEPTH];
  logic [31:0]    instr_mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           full;
  logic           push;
  logic           pop;

  // Full is judged on the occupancy at cycle start, so a same-cycle pop never frees a slot.
  assign full = (count == CW'(FIFO_DEPTH));
  assign push = (state == RUN) && !halt_req && !redirect_valid && !full;
  assign pop  = (count != '0) && if_ready && !redirect_valid;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= BOOT;
      fetch_pc       <= RESET_PC;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      misalign_pulse <= 1'b0;
    end else begin
      misalign_pulse <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        state    <= RUN;
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        unique case (state)
          BOOT:    state <= RUN;
          RUN:     if (halt_req)  state <= HALTED;
          HALTED:  if (!halt_req) state <= RUN;
          default: state <= BOOT;
        endcase
        if (push) begin
          fetch_pc <= fetch_pc + 32'd4;
          wr_ptr   <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the storage array carries no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= imem_instr;
    end
  end

  assign imem_addr  = fetch_pc;
  assign fifo_count = count;
  assign if_valid   = (count != '0);
  assign if_pc      = if_valid ? pc_mem[rd_ptr]    : 32'h0;
  assign if_instr   = if_valid ? instr_mem[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, wrap/reset sequence,
// and randomized traffic against a queue-based reference model.
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt_req = 1'b0;
  logic        if_ready = 1'b0;

  logic [31:0] imem_addr, imem_instr, if_instr, if_pc;
  logic        if_valid, misalign_pulse;
  logic [2:0]  fifo_count;

  logic [31:0] w_imem_addr, w_imem_instr, w_if_instr, w_if_pc;
  logic        w_if_valid, w_misalign_pulse;
  logic [2:0]  w_fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  assign imem_instr   = mem_word(imem_addr);
  assign w_imem_instr = mem_word(w_imem_addr);

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .fifo_count(fifo_count), .misalign_pulse(misalign_pulse)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst(rst), .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .if_valid(w_if_valid), .if_ready(if_ready), .if_instr(w_if_instr), .if_pc(w_if_pc),
    .fifo_count(w_fifo_count), .misalign_pulse(w_misalign_pulse)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc,
                       input logic h, input logic rdy);
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rpc; halt_req = h; if_ready = rdy;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic e_valid, input logic [31:0] e_pc,
                               input int e_count, input logic [31:0] e_addr, input logic e_mis);
    check({tag, ".if_valid"},   32'(if_valid), 32'(e_valid));
    check({tag, ".if_pc"},      if_pc, e_valid ? e_pc : 32'h0);
    check({tag, ".if_instr"},   if_instr, e_valid ? mem_word(e_pc) : 32'h0);
    check({tag, ".fifo_count"}, 32'(fifo_count), 32'(e_count));
    check({tag, ".imem_addr"},  imem_addr, e_addr);
    check({tag, ".misalign"},   32'(misalign_pulse), 32'(e_mis));
  endtask

  // Directed vectors: inputs held for one cycle, outputs expected just after that edge.
  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        halt;
    logic        ready;
    logic        e_valid;
    logic [31:0] e_pc;
    int          e_count;
    logic [31:0] e_addr;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                              input logic h, input logic rdy, input logic ev,
                              input logic [31:0] epc, input int ecnt,
                              input logic [31:0] eaddr, input logic emis);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.halt = h; v.ready = rdy;
    v.e_valid = ev; v.e_pc = epc; v.e_count = ecnt; v.e_addr = eaddr; v.e_mis = emis;
    return v;
  endfunction

  // Reference model: a queue of fetched entries plus the fetch target and mode flags.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_pc;
  bit          m_booting;
  bit          m_halted;
  bit          m_mis;

  task automatic model_step();
    entry_t e;
    bit     may_fetch;
    bit     take;
    if (rst) begin
      mq.delete();
      m_pc = 32'h0; m_booting = 1; m_halted = 0; m_mis = 0;
    end else begin
      m_mis = redirect_valid && (redirect_pc % 4 != 0);
      if (redirect_valid) begin
        mq.delete();
        m_pc = redirect_pc - (redirect_pc % 4);
        m_booting = 0; m_halted = 0;
      end else begin
        may_fetch = !m_booting && !m_halted && !halt_req && (mq.size() < DEPTH);
        take      = (mq.size() > 0) && if_ready;
        if (take) void'(mq.pop_front());
        if (may_fetch) begin
          e.pc = m_pc; e.instr = mem_word(m_pc);
          mq.push_back(e);
          m_pc = m_pc + 32'd4;
        end
        m_halted  = !m_booting && halt_req;
        m_booting = 0;
      end
    end
  endtask

  task automatic model_compare();
    logic        ev;
    logic [31:0] epc;
    ev  = (mq.size() > 0);
    epc = ev ? mq[0].pc : 32'h0;
    check("rnd.if_valid",   32'(if_valid), 32'(ev));
    check("rnd.if_pc",      if_pc, epc);
    check("rnd.if_instr",   if_instr, ev ? mq[0].instr : 32'h0);
    check("rnd.fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("rnd.imem_addr",  imem_addr, m_pc);
    check("rnd.misalign",   32'(misalign_pulse), 32'(m_mis));
  endtask

  initial begin
    // Streaming after reset with decode always ready.
    vecs.push_back(mk(1,0,0,0,1, 0,0,0,32'h00,0));
    vecs.push_back(mk(0,0,0,0,1, 0,0,0,32'h00,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h00,1,32'h04,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h04,1,32'h08,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h08,1,32'h0C,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h0C,1,32'h10,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h10,1,32'h14,0));
    // Back-pressure: fill to DEPTH, fetch PC holds, then drain in order.
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,32'h00,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,32'h00,0));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h00,1,32'h04,0));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h00,2,32'h08,0));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h00,3,32'h0C,0));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h00,4,32'h10,0));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h00,4,32'h10,0));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h00,4,32'h10,0));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h00,4,32'h10,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h04,3,32'h10,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h08,3,32'h14,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h0C,3,32'h18,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h10,3,32'h1C,0));
    // Redirect with three buffered and ready high: flush, no pop.
    vecs.push_back(mk(0,1,32'h40,0,1, 0,0,0,32'h40,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h40,1,32'h44,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h44,1,32'h48,0));
    // Misaligned redirect.
    vecs.push_back(mk(0,1,32'h43,0,1, 0,0,0,32'h40,1));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h40,1,32'h44,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h44,1,32'h48,0));
    // Halt with two buffered: drain, PC frozen, then redirect resumes.
    vecs.push_back(mk(0,0,0,0,0, 1,32'h44,2,32'h4C,0));
    vecs.push_back(mk(0,0,0,1,0, 1,32'h44,2,32'h4C,0));
    vecs.push_back(mk(0,0,0,1,1, 1,32'h48,1,32'h4C,0));
    vecs.push_back(mk(0,0,0,1,1, 0,0,0,32'h4C,0));
    vecs.push_back(mk(0,0,0,1,1, 0,0,0,32'h4C,0));
    vecs.push_back(mk(0,1,32'h100,1,1, 0,0,0,32'h100,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h100,1,32'h104,0));
    // Reset mid-burst overrides a simultaneous redirect.
    vecs.push_back(mk(0,0,0,0,0, 1,32'h100,2,32'h108,0));
    vecs.push_back(mk(1,1,32'h203,0,1, 0,0,0,32'h00,0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].halt, vecs[i].ready);
      settle();
      check_outputs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                    vecs[i].e_count, vecs[i].e_addr, vecs[i].e_mis);
    end

    // PC wrap on the FFFF_FFF8 instance, then reset mid-burst.
    drive(1,0,0,0,1); settle();
    check("wrap.reset_addr", w_imem_addr, 32'hFFFF_FFF8);
    drive(0,0,0,0,1); settle();
    check("wrap.boot_valid", 32'(w_if_valid), 32'h0);
    drive(0,0,0,0,1); settle();
    check("wrap.pc0", w_if_pc, 32'hFFFF_FFF8);
    check("wrap.instr0", w_if_instr, mem_word(32'hFFFF_FFF8));
    drive(0,0,0,0,1); settle();
    check("wrap.pc1", w_if_pc, 32'hFFFF_FFFC);
    drive(0,0,0,0,1); settle();
    check("wrap.pc2", w_if_pc, 32'h0000_0000);
    check("wrap.addr2", w_imem_addr, 32'h0000_0004);
    drive(0,0,0,0,0); settle();
    check("wrap.count_burst", 32'(w_fifo_count), 32'd2);
    drive(1,0,0,0,0); settle();
    check("wrap.count_rst", 32'(w_fifo_count), 32'd0);
    check("wrap.valid_rst", 32'(w_if_valid), 32'h0);
    check("wrap.addr_rst", w_imem_addr, 32'hFFFF_FFF8);

    // Randomized traffic against the reference model.
    drive(1,0,0,0,0); model_step(); settle(); model_compare();
    for (int n = 0; n < 3000; n++) begin
      logic        r, rv, h, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 11) == 0);
      rpc = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'($urandom_range(0, 63));
      if (n % 500 == 250) rpc = 32'hFFFF_FFF4 | 32'($urandom_range(0, 3));
      h   = ($urandom_range(0, 7) == 0) ? !halt_req : halt_req;
      rdy = ($urandom_range(0, 2) != 0);
      drive(r, rv, rpc, h, rdy);
      model_step();
      settle();
      model_compare();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
